// File: rtl/pipe_pkg.sv
// pipe_pkg: shared sizing helper for the valid_reset_pipe slice.
package pipe_pkg;
    function automatic int count_w(int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/valid_reset_stage.sv
// valid_reset_stage: one pipeline stage with a resettable valid flop and a non-reset data follower.
module valid_reset_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q;
    always_comb v_d = clr_i ? 1'b0 : ld_i ? v_i : v_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) v_q <= 1'b0;
        else       v_q <= v_d;
    end
    // Data is only captured alongside a valid entry, so it never needs a reset.
    always_ff @(posedge clk_i) begin
        if (ld_i && v_i) d_q <= d_i;
    end
    assign v_o = v_q;
    assign d_o = d_q;
endmodule

// File: rtl/valid_reset_pipe.sv
// valid_reset_pipe: valid/ready register slice with bubble collapsing, flush and occupancy count.
module valid_reset_pipe
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    input  logic [WIDTH-1:0]            in_data_i,
    output logic                        in_ready_o,
    output logic                        out_valid_o,
    output logic [WIDTH-1:0]            out_data_o,
    input  logic                        out_ready_i,
    output logic [count_w(DEPTH)-1:0]   count_o
);
    localparam int COUNT_W = count_w(DEPTH);
    logic [DEPTH-1:0]   v, ld;
    logic [WIDTH-1:0]   d [DEPTH];
    logic [COUNT_W-1:0] count_q, count_d;
    logic               in_xfer, out_xfer;
    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            // Stage k loads if the output drains or any stage from k onward is empty.
            assign ld[k] = out_ready_i | ~&v[DEPTH-1:k];
            if (k == 0) begin : g_head
                valid_reset_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .clr_i (flush_i),
                    .ld_i  (ld[k]),
                    .v_i   (in_valid_i),
                    .d_i   (in_data_i),
                    .v_o   (v[k]),
                    .d_o   (d[k])
                );
            end else begin : g_follow
                valid_reset_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .clr_i (flush_i),
                    .ld_i  (ld[k]),
                    .v_i   (v[k-1]),
                    .d_i   (d[k-1]),
                    .v_o   (v[k]),
                    .d_o   (d[k])
                );
            end
        end
    endgenerate
    assign in_ready_o  = ld[0] & ~rst_i & ~flush_i;
    assign out_valid_o = v[DEPTH-1];
    assign out_data_o  = d[DEPTH-1];
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;
    always_comb count_d = flush_i ? '0 :
                          (in_xfer & ~out_xfer) ? count_q + 1'b1 :
                          (out_xfer & ~in_xfer) ? count_q - 1'b1 : count_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (count_q <= COUNT_W'(DEPTH) && count_q == COUNT_W'($countones(v)));
    end
    assign count_o = count_q;
endmodule
